// File: rtl/candy_avb_pio_pkg.sv
// Shared constants for the Avalon-MM bidirectional PIO: register map,
// edge-capture encodings and legal parameter ranges.
package candy_avb_pio_pkg;

    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned BUS_W   = 32;
    localparam int unsigned BLANK_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

    localparam int unsigned EDGE_RISING  = 0;
    localparam int unsigned EDGE_FALLING = 1;
    localparam int unsigned EDGE_ANY     = 2;

    localparam int unsigned WIDTH_MIN = 1;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned SYNC_MIN  = 2;
    localparam int unsigned SYNC_MAX  = 4;

endpackage

// File: rtl/candy_avb_pio_sync_edge.sv
// Per-pin input synchroniser, previous-value flop and registered edge pulse.
// The pulse is gated by capture_en so the post-reset blanking window is honoured.
module candy_avb_pio_sync_edge
    import candy_avb_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pin_in,
    input  logic             capture_en,
    output logic [WIDTH-1:0] sync_val,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;
    logic [WIDTH-1:0]                  detect_c;

    assign sync_val = sync_q[SYNC_STAGES-1];

    always_comb begin
        detect_c = sync_val ^ prev_q;
        if (EDGE_TYPE == EDGE_RISING) begin
            detect_c = sync_val & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALLING) begin
            detect_c = ~sync_val & prev_q;
        end
    end

    // Sync and previous-value flops keep running while capture is blanked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '0;
            prev_q     <= '0;
            edge_pulse <= '0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], pin_in};
            prev_q     <= sync_val;
            edge_pulse <= capture_en ? detect_c : '0;
        end
    end

endmodule

// File: rtl/candy_avb_pio_bidir_irq.sv
// Avalon-MM bidirectional PIO: per-pin direction, atomic set/clear outputs,
// edge capture with write-1-to-clear and a maskable level interrupt.
module candy_avb_pio_bidir_irq
    import candy_avb_pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0,
    parameter logic [WIDTH-1:0] DATA_RESET  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    inout  wire  [WIDTH-1:0]  bidir_port
);

    localparam int unsigned BLANK_CYCLES = SYNC_STAGES + 1;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX || SYNC_STAGES < SYNC_MIN ||
        SYNC_STAGES > SYNC_MAX || EDGE_TYPE > EDGE_ANY) begin : g_bad_param
        $error("candy_avb_pio_bidir_irq: parameter out of range");
    end

    logic [WIDTH-1:0]   data_out, dir, irqmask, edgecap;
    logic [WIDTH-1:0]   data_out_d, dir_d, irqmask_d, edgecap_d;
    logic [WIDTH-1:0]   sync_val, edge_pulse, wdata;
    logic [BLANK_W-1:0] blank_cnt;
    logic [BUS_W-1:0]   rdata_c;
    logic               capture_en, wr;
    logic               unused_wdata;

    assign wr           = chipselect & ~write_n;
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;
    assign capture_en   = (blank_cnt == BLANK_W'(BLANK_CYCLES));

    candy_avb_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk        (clk),
        .reset      (reset),
        .pin_in     (bidir_port),
        .capture_en (capture_en),
        .sync_val   (sync_val),
        .edge_pulse (edge_pulse)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign bidir_port[i] = dir[i] ? data_out[i] : 1'bz;
    end

    // Register file next state; a detected edge beats a same-cycle W1C.
    always_comb begin
        data_out_d = data_out;
        dir_d      = dir;
        irqmask_d  = irqmask;
        edgecap_d  = edgecap | edge_pulse;
        if (wr) begin
            case (address)
                ADDR_DATA:    data_out_d = wdata;
                ADDR_DIR:     dir_d      = wdata;
                ADDR_IRQMASK: irqmask_d  = wdata;
                ADDR_EDGECAP: edgecap_d  = (edgecap & ~wdata) | edge_pulse;
                ADDR_OUTSET:  data_out_d = data_out | wdata;
                ADDR_OUTCLR:  data_out_d = data_out & ~wdata;
                default:      ;
            endcase
        end
    end

    always_comb begin
        rdata_c = '0;
        case (address)
            ADDR_DATA:    rdata_c = BUS_W'(sync_val);
            ADDR_DIR:     rdata_c = BUS_W'(dir);
            ADDR_IRQMASK: rdata_c = BUS_W'(irqmask);
            ADDR_EDGECAP: rdata_c = BUS_W'(edgecap);
            default:      rdata_c = '0;
        endcase
    end

    // irq is built from next-state values so it tracks EDGECAP without extra delay.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out  <= DATA_RESET;
            dir       <= DIR_RESET;
            irqmask   <= '0;
            edgecap   <= '0;
            readdata  <= '0;
            irq       <= 1'b0;
            blank_cnt <= '0;
        end else begin
            data_out  <= data_out_d;
            dir       <= dir_d;
            irqmask   <= irqmask_d;
            edgecap   <= edgecap_d;
            readdata  <= rdata_c;
            irq       <= |(edgecap_d & irqmask_d);
            if (!capture_en) begin
                blank_cnt <= blank_cnt + BLANK_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_candy_avb_pio_bidir_irq.sv
// Directed bench for the bidirectional PIO: an 8-bit rising-edge instance and
// a 32-bit any-edge instance sharing one Avalon bus with separate resets.
module tb_candy_avb_pio_bidir_irq;
    import candy_avb_pio_pkg::*;

    logic        clk = 1'b0;
    logic        rst8, rst32;
    logic        chipselect, write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] rdata8, rdata32;
    logic        irq8, irq32;
    wire  [7:0]  pins8;
    wire  [31:0] pins32;
    logic [7:0]  oe8, drv8;
    logic [31:0] oe32, drv32;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_drv8
        assign pins8[i] = oe8[i] ? drv8[i] : 1'bz;
    end
    for (genvar i = 0; i < 32; i++) begin : g_drv32
        assign pins32[i] = oe32[i] ? drv32[i] : 1'bz;
    end

    candy_avb_pio_bidir_irq #(
        .WIDTH (8), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_RISING),
        .DIR_RESET (8'h00), .DATA_RESET (8'h00)
    ) dut8 (
        .clk (clk), .reset (rst8), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (rdata8),
        .irq (irq8), .bidir_port (pins8)
    );

    candy_avb_pio_bidir_irq #(
        .WIDTH (32), .SYNC_STAGES (2), .EDGE_TYPE (EDGE_ANY),
        .DIR_RESET (32'h0), .DATA_RESET (32'h0)
    ) dut32 (
        .clk (clk), .reset (rst32), .address (address), .chipselect (chipselect),
        .write_n (write_n), .writedata (writedata), .readdata (rdata32),
        .irq (irq32), .bidir_port (pins32)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [2:0] a);
        address = a;
        step(1);
    endtask

    initial begin
        rst8 = 1'b1; rst32 = 1'b1;
        chipselect = 1'b0; write_n = 1'b1; address = '0; writedata = '0;
        oe8 = 8'hFF; drv8 = 8'hFF;
        oe32 = 32'hFFFF_FFFF; drv32 = 32'h0;

        // Reset with pins held high; blanking must hide the apparent edge
        step(3);
        check("rst_rdata", rdata8, 32'h0);
        check("rst_irq", 32'(irq8), 32'h0);
        check("rst_pins", 32'(pins8), 32'h0000_00FF);
        rst8 = 1'b0;
        step(10);
        rd(ADDR_EDGECAP); check("blank_edgecap", rdata8, 32'h0);
        rd(ADDR_DIR);     check("rst_dir", rdata8, 32'h0);
        rd(ADDR_DATA);    check("rst_data_in", rdata8, 32'h0000_00FF);

        // Output drive, OUTSET and OUTCLR
        oe8 = 8'hF0; drv8 = 8'hC0;
        wr(ADDR_DIR, 32'h0F);
        wr(ADDR_DATA, 32'hA5);
        check("drive_lo", 32'(pins8[3:0]), 32'h5);
        step(3);
        rd(ADDR_DATA);    check("drive_read", rdata8, 32'h0000_00C5);
        wr(ADDR_OUTSET, 32'h02);
        check("outset_pins", 32'(pins8[3:0]), 32'h7);
        wr(ADDR_OUTCLR, 32'h81);
        check("outclr_pins", 32'(pins8[3:0]), 32'h6);
        rd(ADDR_OUTSET);  check("outset_read", rdata8, 32'h0);
        rd(ADDR_OUTCLR);  check("outclr_read", rdata8, 32'h0);
        rd(ADDR_DIR);     check("dir_read", rdata8, 32'h0000_000F);
        oe8 = 8'h00;
        wr(ADDR_DIR, 32'hFF);
        check("data_out_full", 32'(pins8), 32'h0000_0026);
        wr(3'd6, 32'hFFFF_FFFF);
        rd(3'd6);         check("rsvd6_8", rdata8, 32'h0);

        // Quiesce, then rising-edge latency on pin3
        wr(ADDR_DIR, 32'h00);
        oe8 = 8'hFF; drv8 = 8'h00;
        step(6);
        wr(ADDR_EDGECAP, 32'hFF);
        rd(ADDR_EDGECAP); check("cap_cleared", rdata8, 32'h0);
        drv8 = 8'h08; address = ADDR_DATA;
        step(2);          check("lat_n1", rdata8, 32'h0);
        step(1);          check("lat_n2", rdata8, 32'h0000_0008);
        address = ADDR_EDGECAP;
        step(1);          check("cap_n3", rdata8, 32'h0);
        step(1);          check("cap_n4", rdata8, 32'h0000_0008);
        check("irq_nomask", 32'(irq8), 32'h0);
        drv8 = 8'h00;
        step(5);
        rd(ADDR_EDGECAP); check("fall_ignored", rdata8, 32'h0000_0008);

        // Interrupt mask and W1C
        wr(ADDR_IRQMASK, 32'h08);
        check("irq_set", 32'(irq8), 32'h1);
        wr(ADDR_EDGECAP, 32'h08);
        check("irq_w1c", 32'(irq8), 32'h0);
        drv8 = 8'h08;
        step(5);
        check("irq_recap", 32'(irq8), 32'h1);
        wr(ADDR_IRQMASK, 32'h00);
        check("irq_masked", 32'(irq8), 32'h0);
        rd(ADDR_EDGECAP); check("cap_pending", rdata8, 32'h0000_0008);
        drv8 = 8'h00;
        step(5);
        wr(ADDR_EDGECAP, 32'hFF);

        // Same-cycle detected edge and W1C on pin2: set wins
        drv8 = 8'h04;
        step(5);
        rd(ADDR_EDGECAP); check("coll_pre", rdata8, 32'h0000_0004);
        drv8 = 8'h00;
        step(5);
        drv8 = 8'h04;
        step(3);
        wr(ADDR_EDGECAP, 32'h04);
        rd(ADDR_EDGECAP); check("collision", rdata8, 32'h0000_0004);
        wr(ADDR_EDGECAP, 32'h00);
        rd(ADDR_EDGECAP); check("w1c_zero", rdata8, 32'h0000_0004);
        wr(ADDR_EDGECAP, 32'h04);
        rd(ADDR_EDGECAP); check("w1c_clear", rdata8, 32'h0);

        // 32-bit any-edge instance
        rst32 = 1'b0;
        step(6);
        wr(ADDR_IRQMASK, 32'h8000_0000);
        drv32 = 32'h8000_0000;
        step(5);
        rd(ADDR_EDGECAP); check("any_rise", rdata32, 32'h8000_0000);
        check("irq32_set", 32'(irq32), 32'h1);
        wr(ADDR_EDGECAP, 32'h8000_0000);
        rd(ADDR_EDGECAP); check("any_clr", rdata32, 32'h0);
        drv32 = 32'h0;
        step(5);
        rd(ADDR_EDGECAP); check("any_fall", rdata32, 32'h8000_0000);
        wr(3'd6, 32'hDEAD_BEEF);
        rd(3'd6);         check("rsvd6_32", rdata32, 32'h0);

        // Asynchronous reset in the middle of a toggle
        drv32 = 32'h8000_0000;
        address = ADDR_EDGECAP;
        step(1);          check("pre_reset", rdata32, 32'h8000_0000);
        #2;
        rst32 = 1'b1;
        #1;
        check("async_rdata", rdata32, 32'h0);
        check("async_irq", 32'(irq32), 32'h0);
        @(posedge clk);
        #1;
        rst32 = 1'b0;
        step(10);
        rd(ADDR_EDGECAP); check("post_rst_cap", rdata32, 32'h0);
        rd(ADDR_IRQMASK); check("post_rst_mask", rdata32, 32'h0);
        rd(ADDR_DIR);     check("post_rst_dir", rdata32, 32'h0);
        check("post_rst_irq", 32'(irq32), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
